hamming_enc_sched: RTL and testbench
====================================

// Module: hamming_enc_sched
// PURPOSE
//  Shares one Hamming(21,16) encoder among N_REQ requesters. The block
//  arbitrates round-robin and encodes the granted word combinationally.
//  It registers the codeword and requester ID into a single output slot
//  with valid/ready backpressure. It sits between the data producers and
//  the serializer/storage path, and adds enable/drain control and a word counter.
// PARAMETERS
//  N_REQ  4  number of requesters (>=2); ID_W = $clog2(N_REQ) (localparam)
// PORTS
//  clk        in   1          rising-edge clock
//  rst        in   1          synchronous reset, active-low (0 = reset)
//  en         in   1          1 = grant new words; 0 = stop granting, drain output
//  req_mask   in   N_REQ      1 = requester i eligible for grant
//  req_valid  in   N_REQ      requester i presents a word
//  req_data   in   16*N_REQ   word i = req_data[16*i +: 16]
//  req_ready  out  N_REQ      one-hot (or 0); word i accepted when valid&ready
//  out_valid  out  1          out_code/out_id hold a codeword
//  out_ready  in   1          downstream accepts when out_valid&out_ready
//  out_code   out  21         encoded word, bit index 0..20 = position 1..21
//  out_id     out  ID_W       index of requester that supplied out_code
//  busy       out  1          state != IDLE
//  word_cnt   out  16         count of completed output handshakes
// BEHAVIOUR
//  Encoding (even parity): parity bits at idx 0,1,3,7,15 (position 2^j).
//   Data bits d[0..15] fill the remaining idx 2,4,5,6,8..14,16..20 in
//   ascending order. Parity j = XOR of data bits whose position has bit j set.
//  Reset (rst=0 at posedge): out_valid=0, out_code=0, out_id=0, word_cnt=0,
//   rr_ptr=0, state=IDLE; req_ready=0 combinationally while rst=0.
//   A held codeword is discarded.
//  FSM states:
//   IDLE  -> RUN    on en=1
//   RUN   -> IDLE   on en=0 and slot empty
//   RUN   -> DRAIN  on en=0 and out_valid=1
//   DRAIN -> IDLE   when out_valid=0, or the handshake completes this cycle
//   DRAIN -> RUN    on en=1 (takes priority over the IDLE exit)
//  slot_free = !out_valid | out_ready.
//  Grant:
//   - Only in RUN with slot_free.
//   - Candidates: req_valid & req_mask.
//   - g = first candidate at or after rr_ptr, searched upward with wrap N_REQ-1 -> 0.
//   - req_ready[g] = 1 combinationally; all other bits 0.
//   - req_ready never depends on req_valid of the same index except via g.
//  Transfer cycle: next edge out_valid<=1, out_code<=enc(word g), out_id<=g,
//   rr_ptr<=(g+1) mod N_REQ. Latency = 1 cycle from accept to out_valid.
//  Hold: while out_valid & !out_ready, out_code/out_id are stable and no
//   grant is issued.
//  Simultaneous output pop and new accept in the same cycle: the slot is
//   replaced with the new word; there is no bubble, giving full throughput.
//  Pop without a new accept: out_valid<=0; out_code/out_id keep their last value.
//  No candidates: rr_ptr is unchanged.
//  req_mask/en changes apply to the grant of the same cycle.
//  word_cnt += 1 per out_valid&out_ready and wraps 16'hFFFF -> 0.
// TESTING
//  1 rst=0 two cycles with req_valid all 1 -> req_ready=0, out_valid=0,
//    word_cnt=0, busy=0.
//  2 en=1, req0 data 16'h0001, out_ready=1 -> out_code=21'h000007,
//    out_id=0 one cycle later.
//  3 req1 data 16'hFFFF -> out_code=21'h1FFFFE; data 16'h0000 -> 21'h000000.
//  4 All 4 requesters valid, mask 4'b1111, out_ready=1 -> grants 0,1,2,3,0
//    on consecutive cycles with no bubble. With mask=4'b1010 -> grants 1,3,1.
//  5 out_ready=0 for 5 cycles with out_valid=1 -> out_code stable and
//    req_ready=0; out_ready=1 -> handshake and new grant in the same cycle.
//  6 en=0 while out_valid=1, out_ready=0 -> state DRAIN, busy=1, no grants;
//    out_ready=1 -> IDLE next cycle. Preload word_cnt to 16'hFFFF via 65535
//    words, plus one more -> 0.

Source files
------------

// File: rtl/hamming_enc_sched.sv
// Round-robin scheduler sharing one Hamming(21,16) even-parity encoder among
// N_REQ requesters, with a single registered output slot (valid/ready),
// enable/drain control and a completed-word counter.
module hamming_enc_sched #(
  parameter int unsigned N_REQ = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [N_REQ-1:0]         req_mask,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [16*N_REQ-1:0]      req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [20:0]              out_code,
  output logic [$clog2(N_REQ)-1:0] out_id,
  output logic                     busy,
  output logic [15:0]              word_cnt
);

  localparam int unsigned ID_W = $clog2(N_REQ);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]      state_q, state_d;
  logic            out_valid_q;
  logic [20:0]     out_code_q;
  logic [ID_W-1:0] out_id_q;
  logic [ID_W-1:0] rr_ptr_q;
  logic [15:0]     word_cnt_q;

  logic [N_REQ-1:0] cand;
  logic             found;
  logic [ID_W-1:0]  gnt;
  logic [15:0]      gnt_data;
  logic             slot_free;
  logic             accept;
  logic             pop;

  // Position p (1..21) sits at index p-1; powers of two carry parity, the
  // rest take data bits in ascending order. Parity j covers positions with bit j set.
  function automatic logic [20:0] enc(input logic [15:0] d);
    logic [20:0] c;
    logic [3:0]  k;
    logic        par;
    c = '0;
    k = '0;
    for (int p = 1; p <= 21; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[5'(p - 1)] = d[k];
        k = k + 4'd1;
      end
    end
    for (int j = 0; j < 5; j++) begin
      par = 1'b0;
      for (int p = 1; p <= 21; p++) begin
        if ((((p >> j) & 1) == 1) && ((p & (p - 1)) != 0)) par = par ^ c[5'(p - 1)];
      end
      c[5'((1 << j) - 1)] = par;
    end
    return c;
  endfunction

  // Round-robin search: first eligible requester at or after rr_ptr, wrapping.
  always_comb begin
    int unsigned idx;
    cand     = req_valid & req_mask;
    found    = 1'b0;
    gnt      = '0;
    gnt_data = '0;
    idx      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % N_REQ;
      if (!found && cand[ID_W'(idx)]) begin
        found = 1'b1;
        gnt   = ID_W'(idx);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (ID_W'(i) == gnt) gnt_data = req_data[16*i +: 16];
    end
  end

  // Grant qualification and one-hot ready; en/mask act on the same cycle.
  always_comb begin
    slot_free = !out_valid_q || out_ready;
    pop       = out_valid_q && out_ready;
    accept    = rst && (state_q == ST_RUN) && en && slot_free && found;
    req_ready = '0;
    if (accept) req_ready[gnt] = 1'b1;
  end

  // Control FSM next state; returning to RUN wins over leaving DRAIN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (en) state_d = ST_RUN;
      ST_RUN:   if (!en) state_d = out_valid_q ? ST_DRAIN : ST_IDLE;
      ST_DRAIN: begin
        if (en)                            state_d = ST_RUN;
        else if (!out_valid_q || out_ready) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output slot, pointer, counter and state registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_code_q  <= '0;
      out_id_q    <= '0;
      rr_ptr_q    <= '0;
      word_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        out_valid_q <= 1'b1;
        out_code_q  <= enc(gnt_data);
        out_id_q    <= gnt;
        rr_ptr_q    <= (gnt == ID_W'(N_REQ - 1)) ? '0 : gnt + ID_W'(1);
      end else if (pop) begin
        out_valid_q <= 1'b0;
      end
      if (pop) word_cnt_q <= word_cnt_q + 16'd1;
    end
  end

  assign out_valid = out_valid_q;
  assign out_code  = out_code_q;
  assign out_id    = out_id_q;
  assign busy      = (state_q != ST_IDLE);
  assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_hamming_enc_sched.sv
// Directed bench for hamming_enc_sched with hand-computed codewords.
module tb_hamming_enc_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  req_mask;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic        out_ready;
  logic [20:0] out_code;
  logic [1:0]  out_id;
  logic        busy;
  logic [15:0] word_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  hamming_enc_sched #(.N_REQ(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req_mask  (req_mask),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .out_id    (out_id),
    .busy      (busy),
    .word_cnt  (word_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Codewords: 0001->000007, FFFF->1FFFFE, 0000->000000, 0002->000019
  int          gseq [8] = '{0, 1, 2, 3, 0, 1, 3, 1};
  logic [20:0] cseq [4] = '{21'h000007, 21'h1FFFFE, 21'h000000, 21'h000019};

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; en = 1'b1; req_mask = 4'b1111; req_valid = 4'b1111;
    req_data = {16'h0002, 16'h0000, 16'hFFFF, 16'h0001}; out_ready = 1'b0;

    // Reset held two cycles with every requester valid
    tick();
    @(negedge clk);
    check("rst_ready_c1", 32'(req_ready), 32'h0);
    tick();
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_word_cnt", 32'(word_cnt), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_out_code", 32'(out_code), 32'h0);

    // Single word from requester 0
    tick();
    rst = 1'b1; en = 1'b1; req_valid = 4'b0001; out_ready = 1'b1;
    @(negedge clk);
    check("idle_no_grant", 32'(req_ready), 32'h0);
    tick();
    @(negedge clk);
    check("run_busy", 32'(busy), 32'h1);
    check("grant0_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0000;
    @(negedge clk);
    check("w0001_valid", 32'(out_valid), 32'h1);
    check("w0001_code", 32'(out_code), 32'h000007);
    check("w0001_id", 32'(out_id), 32'h0);

    // Requester 1: all-ones then all-zeros (wraps back to the only candidate)
    req_valid = 4'b0010;
    @(negedge clk);
    check("grant1_ready", 32'(req_ready), 32'h2);
    tick();
    req_data[31:16] = 16'h0000;
    @(negedge clk);
    check("wFFFF_code", 32'(out_code), 32'h1FFFFE);
    check("wFFFF_id", 32'(out_id), 32'h1);
    check("grant1_wrap_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'b0000;
    @(negedge clk);
    check("w0000_code", 32'(out_code), 32'h000000);
    check("w0000_id", 32'(out_id), 32'h1);

    // Fresh start so rr_ptr is 0, then round-robin with full throughput
    rst = 1'b0;
    tick();
    rst = 1'b1;
    req_data = {16'h0002, 16'h0000, 16'hFFFF, 16'h0001};
    tick();
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      if (i >= 5) req_mask = 4'b1010;
      @(negedge clk);
      check($sformatf("rr_ready_%0d", i), 32'(req_ready), 32'(1 << gseq[i]));
      if (i > 0) begin
        check($sformatf("rr_valid_%0d", i), 32'(out_valid), 32'h1);
        check($sformatf("rr_id_%0d", i), 32'(out_id), 32'(gseq[i-1]));
        check($sformatf("rr_code_%0d", i), 32'(out_code), 32'(cseq[gseq[i-1]]));
      end
      tick();
    end
    out_ready = 1'b0;
    @(negedge clk);
    check("rr_id_last", 32'(out_id), 32'h1);
    check("rr_code_last", 32'(out_code), 32'h1FFFFE);

    // Hold under backpressure
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("hold_ready_%0d", i), 32'(req_ready), 32'h0);
      check($sformatf("hold_code_%0d", i), 32'(out_code), 32'h1FFFFE);
      check($sformatf("hold_valid_%0d", i), 32'(out_valid), 32'h1);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("release_ready", 32'(req_ready), 32'h8);
    tick();
    en = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("release_id", 32'(out_id), 32'h3);
    check("release_code", 32'(out_code), 32'h000019);
    check("release_cnt", 32'(word_cnt), 32'd8);

    // Drain: en dropped with a held word
    check("en0_ready", 32'(req_ready), 32'h0);
    tick();
    @(negedge clk);
    check("drain_busy", 32'(busy), 32'h1);
    check("drain_ready", 32'(req_ready), 32'h0);
    tick();
    @(negedge clk);
    check("drain_busy2", 32'(busy), 32'h1);
    check("drain_valid", 32'(out_valid), 32'h1);
    out_ready = 1'b1;
    @(negedge clk);
    check("drain_pop_ready", 32'(req_ready), 32'h0);
    tick();
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'h0);
    check("idle_valid", 32'(out_valid), 32'h0);
    check("idle_cnt", 32'(word_cnt), 32'd9);
    check("idle_code_kept", 32'(out_code), 32'h000019);

    // Counter wrap: 65535 handshakes then one more
    rst = 1'b0;
    tick();
    rst = 1'b1; en = 1'b1; req_mask = 4'b1111; req_valid = 4'b0000;
    tick();
    req_valid = 4'b1111;
    repeat (65536) tick();
    req_valid = 4'b0000;
    @(negedge clk);
    check("cnt_ffff", 32'(word_cnt), 32'hFFFF);
    tick();
    @(negedge clk);
    check("cnt_wrap", 32'(word_cnt), 32'h0);
    check("cnt_wrap_valid", 32'(out_valid), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
